// File: rtl/riscv_pkg.sv
// Shared RV64 encoding constants: opcodes, op-class encoding, immediate ranges.
// Used by the instruction encoder and the immediate decoder.
package riscv_pkg;

    // Major opcodes, bits [6:0] of the instruction word
    localparam logic [6:0] OPC_RT  = 7'b0110011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    // Op-class encoding carried on the in_op field bundle
    typedef enum logic [1:0] {
        OP_RT  = 2'd0,
        OP_LW  = 2'd1,
        OP_SW  = 2'd2,
        OP_BEQ = 2'd3
    } op_e;

    // Legal immediate ranges: 12-bit I/S and 13-bit even B offsets
    localparam longint IMM12_MIN = -64'sd2048;
    localparam longint IMM12_MAX = 64'sd2047;
    localparam longint IMM13_MIN = -64'sd4096;
    localparam longint IMM13_MAX = 64'sd4094;

    function automatic logic [6:0] opcode_of(op_e op);
        logic [6:0] opc;
        unique case (op)
            OP_RT:   opc = OPC_RT;
            OP_LW:   opc = OPC_LW;
            OP_SW:   opc = OPC_SW;
            default: opc = OPC_BEQ;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry valid/ready FIFO holding encoded {instr, addr} words.
// Ports: push_* (producer side), pop_* (consumer side). push_ready_o is
// derived from registered occupancy only, so pop_ready_i never reaches it.
module enc_fifo2 #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    input  logic [W-1:0] push_data_i,
    output logic         pop_valid_o,
    input  logic         pop_ready_i,
    output logic [W-1:0] pop_data_o
);

    logic [W-1:0] slot0_q;
    logic [W-1:0] slot1_q;
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         live_q;
    logic         push;
    logic         pop;

    // live_q keeps ready low while reset is held and for the release cycle
    assign push_ready_o = live_q & (cnt_q != 2'd2);
    assign pop_valid_o  = (cnt_q != 2'd0);
    assign pop_data_o   = rd_q ? slot1_q : slot0_q;

    assign push = push_valid_i & push_ready_o;
    assign pop  = pop_valid_o & pop_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= 2'd0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            cnt_q  <= cnt_d;
            if (push) begin
                if (wr_q) begin
                    slot1_q <= push_data_i;
                end else begin
                    slot0_q <= push_data_i;
                end
                wr_q <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV64 encoder: packs decoded fields into R/LW/SW/BEQ words,
// tags each with a byte address and buffers it in a 2-entry FIFO.
// Ports: base_load/base_addr (address counter load), in_* (field bundle,
// valid/ready), out_* (word + address, valid/ready), err/err_count.
// Macro ENC_RANGE_CHECK_EN enables immediate range checking; without it
// err and err_count are tied to 0 and immediates are silently truncated.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int INSTRSIZE = 32,
    parameter int IMMSIZE   = 64,
    parameter int ADDRSIZE  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 base_load,
    input  logic [ADDRSIZE-1:0]  base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [IMMSIZE-1:0]   in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTRSIZE-1:0] out_instr,
    output logic [ADDRSIZE-1:0]  out_addr,
    output logic                 err,
    output logic [7:0]           err_count
);

    localparam int FW = INSTRSIZE + ADDRSIZE;

    function automatic logic [31:0] pack(
        input op_e        op,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [2:0] f3,
        input logic [6:0] f7,
        input logic [12:0] imm
    );
        logic [31:0] w;
        logic [6:0]  opc;
        opc = opcode_of(op);
        unique case (op)
            OP_RT:   w = {f7, rs2, rs1, f3, rd, opc};
            OP_LW:   w = {imm[11:0], rs1, f3, rd, opc};
            OP_SW:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            default: w = {imm[12], imm[10:5], rs2, rs1, f3,
                          imm[4:1], imm[11], opc};
        endcase
        return w;
    endfunction

    op_e                 op;
    logic                accept;
    logic [ADDRSIZE-1:0] base_al;
    logic [ADDRSIZE-1:0] pc_q;
    logic [ADDRSIZE-1:0] pc_d;
    logic [ADDRSIZE-1:0] entry_addr;
    logic [31:0]         word;
    logic [FW-1:0]       fifo_in;
    logic [FW-1:0]       fifo_out;
    logic                unused_bits;

    assign op     = op_e'(in_op);
    assign accept = in_valid & in_ready;

    // Word addresses are 4-byte aligned regardless of base_addr[1:0]
    assign base_al = {base_addr[ADDRSIZE-1:2], 2'b00};

    // A same-cycle load wins: the accepted word takes the new base,
    // and the counter steps past it. Without an accept the counter
    // just follows the selected value.
    assign entry_addr = base_load ? base_al : pc_q;
    assign pc_d = accept ? entry_addr + ADDRSIZE'(4) : entry_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign word = pack(op, in_rd, in_rs1, in_rs2,
                       in_funct3, in_funct7, in_imm[12:0]);

    assign fifo_in = {INSTRSIZE'(word), entry_addr};

    enc_fifo2 #(
        .W (FW)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (in_valid),
        .push_ready_o (in_ready),
        .push_data_i  (fifo_in),
        .pop_valid_o  (out_valid),
        .pop_ready_i  (out_ready),
        .pop_data_o   (fifo_out)
    );

    assign out_instr = fifo_out[FW-1:ADDRSIZE];
    assign out_addr  = fifo_out[ADDRSIZE-1:0];

`ifdef ENC_RANGE_CHECK_EN
    logic signed [IMMSIZE-1:0] imm_s;
    logic                      viol;
    logic                      err_q;
    logic [7:0]                errc_q;

    assign imm_s = $signed(in_imm);

    always_comb begin
        viol = 1'b0;
        unique case (op)
            OP_LW, OP_SW: begin
                viol = (imm_s < IMMSIZE'(IMM12_MIN))
                     | (imm_s > IMMSIZE'(IMM12_MAX));
            end
            OP_BEQ: begin
                viol = (imm_s < IMMSIZE'(IMM13_MIN))
                     | (imm_s > IMMSIZE'(IMM13_MAX))
                     | in_imm[0];
            end
            default: viol = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            errc_q <= 8'd0;
        end else if (accept && viol) begin
            err_q <= 1'b1;
            if (errc_q != 8'hFF) begin
                errc_q <= errc_q + 8'd1;
            end
        end
    end

    assign err       = err_q;
    assign err_count = errc_q;
`else
    assign err       = 1'b0;
    assign err_count = 8'd0;
`endif

    // Address low bits and high immediate bits have no consumer here
    assign unused_bits = ^{base_addr[1:0], in_imm};

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        base_load;
    logic [63:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic        err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

`ifdef ENC_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [63:0] addr;
    } exp_t;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_load (base_load),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding from field positions, by place-value arithmetic
    function automatic logic [31:0] ref_enc(input int op, input int rd,
        input int rs1, input int rs2, input int f3, input int f7,
        input longint imm);
        longint unsigned u, r, regs;
        u = imm;
        regs = longint'(rs1) * (64'd1 << 15) + longint'(f3) * (64'd1 << 12);
        case (op)
            0: r = longint'(f7) * (64'd1 << 25) + longint'(rs2) * (64'd1 << 20)
                 + regs + longint'(rd) * 128 + 51;
            1: r = (u % 4096) * (64'd1 << 20) + regs + longint'(rd) * 128 + 3;
            2: r = ((u / 32) % 128) * (64'd1 << 25)
                 + longint'(rs2) * (64'd1 << 20) + regs + (u % 32) * 128 + 35;
            default: r = ((u / 4096) % 2) * (64'd1 << 31)
                 + ((u / 32) % 64) * (64'd1 << 25)
                 + longint'(rs2) * (64'd1 << 20) + regs
                 + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128 + 99;
        endcase
        return r[31:0];
    endfunction

    function automatic bit ref_viol(input int op, input longint imm);
        if (op == 1 || op == 2) return (imm < -2048) || (imm > 2047);
        if (op == 3) return (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
        return 1'b0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int op, input int rd, input int rs1,
        input int rs2, input int f3, input int f7, input longint imm);
        in_valid  = 1'b1;
        in_op     = 2'(op);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = 64'(imm);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        base_load = 1'b0;
        base_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL ready_timeout in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        base_load = 1'b0;
        base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags v/r/e=%b want 000",
                     {out_valid, in_ready, err});
        end
        checks++;
        if (out_instr !== 32'h0 || out_addr !== 64'h0 || err_count !== 8'h0) begin
            errors++;
            $display("FAIL reset_data instr=%h addr=%h cnt=%0d want 0",
                     out_instr, out_addr, err_count);
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_lw();
        apply_reset();
        wait_ready();
        base_load = 1'b1;
        base_addr = 64'h1000;
        cycle();
        base_load = 1'b0;
        set_in(1, 5, 2, 0, 3, 0, 8);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00813283
            || out_addr !== 64'h1000) begin
            errors++;
            $display("FAIL lw_word v=%b instr=%h addr=%h want 1 00813283 1000",
                     out_valid, out_instr, out_addr);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lw_drain out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        wait_ready();
        out_ready = 1'b1;
        set_in(2, 0, 2, 5, 3, 0, -8);
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'hFE513C23
            || out_addr !== 64'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sw v=%b instr=%h addr=%h rdy=%b want 1 FE513C23 0 1",
                     out_valid, out_instr, out_addr, in_ready);
        end
        set_in(3, 0, 1, 2, 0, 0, 16);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00208863
            || out_addr !== 64'h4) begin
            errors++;
            $display("FAIL b2b_beq v=%b instr=%h addr=%h want 1 00208863 4",
                     out_valid, out_instr, out_addr);
        end
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] wa, wb, wc;
        int r;
        apply_reset();
        wait_ready();
        r = int'($urandom_range(0, 31));
        wa = ref_enc(0, r, 3, 4, 1, 32, 0);
        wb = ref_enc(1, 7, r, 0, 2, 0, -5);
        wc = ref_enc(0, 9, 10, r, 7, 1, 0);
        set_in(0, r, 3, 4, 1, 32, 0);
        cycle();
        set_in(1, 7, r, 0, 2, 0, -5);
        cycle();
        set_in(0, 9, 10, r, 7, 1, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_instr !== wa || out_addr !== 64'h0) begin
                errors++;
                $display("FAIL bp_hold%0d rdy=%b instr=%h addr=%h want 0 %h 0",
                         i, in_ready, out_instr, out_addr, wa);
            end
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_instr !== wb || out_addr !== 64'h4) begin
            errors++;
            $display("FAIL bp_second instr=%h addr=%h want %h 4",
                     out_instr, out_addr, wb);
        end
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== wc || out_addr !== 64'h8) begin
            errors++;
            $display("FAIL bp_third v=%b instr=%h addr=%h want 1 %h 8",
                     out_valid, out_instr, out_addr, wc);
        end
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_range();
        logic [31:0] wl, wbq;
        apply_reset();
        wait_ready();
        wl  = ref_enc(1, 1, 2, 0, 2, 0, 2048);
        wbq = ref_enc(3, 0, 3, 4, 0, 0, 3);
        set_in(1, 1, 2, 0, 2, 0, 2048);
        cycle();
        set_in(3, 0, 3, 4, 0, 0, 3);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_instr !== wl) begin
            errors++;
            $display("FAIL range_lw_word instr=%h want %h", out_instr, wl);
        end
        checks++;
        if (err !== RANGE_ON || err_count !== (RANGE_ON ? 8'd2 : 8'd0)) begin
            errors++;
            $display("FAIL range_err err=%b cnt=%0d want %b %0d",
                     err, err_count, RANGE_ON, RANGE_ON ? 2 : 0);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_instr !== wbq || out_addr !== 64'h4) begin
            errors++;
            $display("FAIL range_beq_word instr=%h addr=%h want %h 4",
                     out_instr, out_addr, wbq);
        end
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_base_load();
        apply_reset();
        wait_ready();
        set_in(0, 1, 1, 1, 0, 0, 0);
        cycle();
        set_in(0, 2, 2, 2, 0, 0, 0);
        base_load = 1'b1;
        base_addr = 64'h23;
        cycle();
        base_load = 1'b0;
        set_in(0, 3, 3, 3, 0, 0, 0);
        out_ready = 1'b1;
        checks++;
        if (out_addr !== 64'h0) begin
            errors++;
            $display("FAIL bl_old addr=%h want 0", out_addr);
        end
        cycle();
        checks++;
        if (out_addr !== 64'h20 || out_instr !== ref_enc(0, 2, 2, 2, 0, 0, 0)) begin
            errors++;
            $display("FAIL bl_new addr=%h want 20", out_addr);
        end
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_addr !== 64'h24 || out_instr !== ref_enc(0, 3, 3, 3, 0, 0, 0)) begin
            errors++;
            $display("FAIL bl_next addr=%h want 24", out_addr);
        end
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        wait_ready();
        set_in(1, 4, 4, 0, 0, 0, 12);
        cycle();
        set_in(1, 5, 5, 0, 0, 0, 16);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full v=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 64'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset v=%b addr=%h rdy=%b want 0 0 0",
                     out_valid, out_addr, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready();
        set_in(1, 6, 6, 0, 0, 0, 20);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 64'h0) begin
            errors++;
            $display("FAIL mid_counter v=%b addr=%h want 1 0", out_valid, out_addr);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        exp_t   q[$];
        exp_t   e;
        longint unsigned m_pc;
        bit     m_err;
        int     m_errc;
        int     op, rd, rs1, rs2, f3, f7;
        longint imm;
        bit     acc, pop;
        apply_reset();
        wait_ready();
        m_pc = 0;
        m_err = 0;
        m_errc = 0;
        for (int c = 0; c < 800; c++) begin
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_flags c=%0d v=%b rdy=%b want occupancy %0d",
                         c, out_valid, in_ready, q.size());
            end
            if (q.size() > 0) begin
                checks++;
                if (out_instr !== q[0].instr || out_addr !== q[0].addr) begin
                    errors++;
                    $display("FAIL rnd_word c=%0d instr=%h addr=%h want %h %h",
                             c, out_instr, out_addr, q[0].instr, q[0].addr);
                end
            end
            checks++;
            if (err !== m_err || err_count !== 8'(m_errc)) begin
                errors++;
                $display("FAIL rnd_err c=%0d err=%b cnt=%0d want %b %0d",
                         c, err, err_count, m_err, m_errc);
            end
            op  = int'($urandom_range(0, 3));
            rd  = int'($urandom_range(0, 31));
            rs1 = int'($urandom_range(0, 31));
            rs2 = int'($urandom_range(0, 31));
            f3  = int'($urandom_range(0, 7));
            f7  = int'($urandom_range(0, 127));
            if ($urandom_range(0, 9) < 8)
                imm = longint'($urandom_range(0, 8400)) - 4200;
            else
                imm = longint'({$urandom, $urandom});
            set_in(op, rd, rs1, rs2, f3, f7, imm);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            base_load = ($urandom_range(0, 11) == 0);
            base_addr = {$urandom, $urandom};
            acc = in_valid && (q.size() < 2);
            pop = out_ready && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (base_load) m_pc = base_addr - (base_addr % 4);
            if (acc) begin
                e.instr = ref_enc(op, rd, rs1, rs2, f3, f7, imm);
                e.addr  = m_pc;
                q.push_back(e);
                m_pc = m_pc + 4;
                if (RANGE_ON && ref_viol(op, imm)) begin
                    m_err = 1'b1;
                    if (m_errc < 255) m_errc++;
                end
            end
            cycle();
        end
        in_valid = 1'b0;
        base_load = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        apply_reset();
        wait_ready();
        out_ready = 1'b1;
        set_in(2, 0, 1, 1, 0, 0, 5000);
        repeat (300) cycle();
        in_valid = 1'b0;
        checks++;
        if (err_count !== (RANGE_ON ? 8'd255 : 8'd0) || err !== RANGE_ON) begin
            errors++;
            $display("FAIL sat_count cnt=%0d err=%b want %0d %b",
                     err_count, err, RANGE_ON ? 255 : 0, RANGE_ON);
        end
        cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        base_load = 1'b0;
        base_addr = '0;
        in_op = '0;
        in_rd = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm = '0;
        test_reset();
        test_lw();
        test_back_to_back();
        test_backpressure();
        test_range();
        test_base_load();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
